// File: rtl/mul_pkg.sv
// Shared types and helpers for the M-extension multiply sequencer.
// Operand extension and result-half selection live here.
package mul_pkg;

  localparam int MUL_XLEN = 32;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } mul_state_t;

  // MUL is treated as signed x signed; its low half ignores the top bit
  function automatic logic [2*MUL_XLEN+1:0] ext_operands(
    input mul_op_t               op,
    input logic [MUL_XLEN-1:0]   a,
    input logic [MUL_XLEN-1:0]   b
  );
    logic sa;
    logic sb;
    sa = a[MUL_XLEN-1] & (op != OP_MULHU);
    sb = b[MUL_XLEN-1] & ((op == OP_MUL) || (op == OP_MULH));
    return {sa, a, sb, b};
  endfunction

  function automatic logic [MUL_XLEN-1:0] sel_result(
    input mul_op_t                 op,
    input logic [2*MUL_XLEN+1:0]   prod
  );
    if (op == OP_MUL) return prod[MUL_XLEN-1:0];
    return prod[2*MUL_XLEN-1:MUL_XLEN];
  endfunction

endpackage

// File: rtl/multiply_signed.sv
// Iterative radix-2 Booth multiplier, signed A_W x B_W operands.
// One step per clock after stb; ack pulses with the product in o.
module multiply_signed #(
  parameter int A_W = 33,
  parameter int B_W = 33
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stb,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               ack,
  output logic [A_W+B_W-1:0] o
);

  localparam int CW = $clog2(B_W + 1);

  logic [A_W:0]       r_m;
  logic [A_W:0]       r_acc;
  logic [B_W-1:0]     r_q;
  logic               r_q1;
  logic               r_run;
  logic [CW-1:0]      r_cnt;
  logic [A_W:0]       w_sum;
  logic [A_W+B_W+1:0] w_sh;

  // Booth add/subtract then arithmetic shift of {acc, q, q-1}
  always_comb begin
    unique case ({r_q[0], r_q1})
      2'b01:   w_sum = r_acc + r_m;
      2'b10:   w_sum = r_acc - r_m;
      default: w_sum = r_acc;
    endcase
    w_sh = {w_sum[A_W], w_sum, r_q};
  end

  // Step counter and completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run <= 1'b0;
      ack   <= 1'b0;
      r_cnt <= '0;
    end else begin
      ack <= 1'b0;
      if (stb) begin
        r_run <= 1'b1;
        r_cnt <= CW'(B_W);
      end else if (r_run) begin
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_run <= 1'b0;
          ack   <= 1'b1;
        end
      end
    end
  end

  // Datapath: load on stb, shift each running cycle
  always_ff @(posedge clk) begin
    if (stb) begin
      r_m   <= {a[A_W-1], a};
      r_acc <= '0;
      r_q   <= b;
      r_q1  <= 1'b0;
    end else if (r_run) begin
      r_acc <= w_sh[A_W+B_W+1:B_W+1];
      r_q   <= w_sh[B_W:1];
      r_q1  <= w_sh[0];
      if (r_cnt == CW'(1)) o <= w_sh[A_W+B_W:1];
    end
  end

endmodule

// File: rtl/mul_ctrl.sv
// Sequencer for MUL/MULH/MULHSU/MULHU around one Booth multiplier.
// One-entry product cache lets MULH* followed by MUL share a multiply.
module mul_ctrl
  import mul_pkg::*;
#(
  parameter int XLEN = MUL_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  localparam int EW = XLEN + 1;
  localparam int PW = 2 * EW;

  mul_state_t      r_state;
  mul_state_t      w_next;
  mul_op_t         r_op;
  logic [EW-1:0]   r_a;
  logic [EW-1:0]   r_b;
  logic [EW-1:0]   r_ca;
  logic [EW-1:0]   r_cb;
  logic [PW-1:0]   r_cp;
  logic            r_cvld;
  logic [2*EW-1:0] w_ext;
  logic [EW-1:0]   w_ea;
  logic [EW-1:0]   w_eb;
  logic            w_hit;
  logic            w_acc;
  logic            w_stb;
  logic            w_ack;
  logic            w_rst;
  logic            w_fill;
  logic            w_drop;
  logic [PW-1:0]   w_prod;

  assign w_ext = ext_operands(mul_op_t'(req_op), req_a, req_b);
  assign w_ea  = w_ext[2*EW-1:EW];
  assign w_eb  = w_ext[EW-1:0];
  assign w_rst = ~rst_n;

  assign req_ready  = (r_state == S_IDLE) && !flush;
  assign w_acc      = req_valid && req_ready;
  assign w_stb      = (r_state == S_ISSUE) && !flush;
  assign resp_valid = (r_state == S_RESP) && !flush;
  assign resp_data  = sel_result(r_op, r_cp);
  assign busy       = (r_state != S_IDLE);

  assign w_fill = (r_state == S_WAIT) && w_ack && !flush;
  assign w_drop = w_ack && ((r_state == S_DRAIN) ||
                  ((r_state == S_WAIT) && flush));

  // Cache hit: MUL only needs the low halves to match
  always_comb begin
    w_hit = 1'b0;
    if (r_cvld) begin
      if (req_op == OP_MUL)
        w_hit = (w_ea[XLEN-1:0] == r_ca[XLEN-1:0]) &&
                (w_eb[XLEN-1:0] == r_cb[XLEN-1:0]);
      else
        w_hit = (w_ea == r_ca) && (w_eb == r_cb);
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_acc) w_next = w_hit ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = flush ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (flush)      w_next = w_ack ? S_IDLE : S_DRAIN;
        else if (w_ack) w_next = S_RESP;
      end
      S_RESP:  if (flush || resp_ready) w_next = S_IDLE;
      S_DRAIN: if (w_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State and cache-valid registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cvld  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_fill)      r_cvld <= 1'b1;
      else if (w_drop) r_cvld <= 1'b0;
    end
  end

  // Request latch and cache contents
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_op <= mul_op_t'(req_op);
      r_a  <= w_ea;
      r_b  <= w_eb;
    end
    if (w_fill) begin
      r_ca <= r_a;
      r_cb <= r_b;
      r_cp <= w_prod;
    end
  end

  multiply_signed #(
    .A_W (EW),
    .B_W (EW)
  ) u_mul (
    .clk (clk),
    .rst (w_rst),
    .stb (w_stb),
    .a   (r_a),
    .b   (r_b),
    .ack (w_ack),
    .o   (w_prod)
  );

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl.
// Arithmetic reference model with a one-entry operand cache.
module tb_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int stb_cnt = 0;

  bit          m_vld = 1'b0;
  logic [1:0]  m_op = 2'd0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;

  mul_ctrl #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dut.w_stb) stb_cnt++;

  function automatic longint ext_val(input logic [1:0] op,
                                     input logic [31:0] x,
                                     input bit is_a);
    bit sgn;
    sgn = is_a ? (op != 2'd3) : (op == 2'd0 || op == 2'd1);
    if (sgn) return longint'($signed(x));
    return longint'({32'b0, x});
  endfunction

  function automatic bit model_hit(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
    if (!m_vld) return 1'b0;
    if (op == 2'd0) return (a == m_a) && (b == m_b);
    return (ext_val(op, a, 1'b1) == ext_val(m_op, m_a, 1'b1)) &&
           (ext_val(op, b, 1'b0) == ext_val(m_op, m_b, 1'b0));
  endfunction

  function automatic logic [31:0] model_res(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'd0: p = {32'b0, a} * {32'b0, b};
      2'd1: p = longint'($signed(a)) * longint'($signed(b));
      2'd2: p = longint'($signed(a)) * longint'({32'b0, b});
      default: p = {32'b0, a} * {32'b0, b};
    endcase
    if (op == 2'd0) return p[31:0];
    return p[63:32];
  endfunction

  task automatic run_req(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold,
                         output int lat, output logic [31:0] data,
                         output bit stable, output bit ok);
    int n;
    bit h;
    h = model_hit(op, a, b);
    ok = 1'b0;
    stable = 1'b1;
    lat = 0;
    data = '0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    resp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) return;
    data = resp_data;
    repeat (hold) begin
      @(negedge clk);
      if (!resp_valid || resp_data !== data) stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    ok = 1'b1;
    if (!h) begin
      m_vld = 1'b1;
      m_op = op;
      m_a = a;
      m_b = b;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_vld = 1'b0;
    @(negedge clk);
    tests++;
    if (resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_resp_valid: got %b want 0", resp_valid);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_mulh_edge;
    int lat;
    logic [31:0] d;
    bit st, ok;
    run_req(2'd1, 32'h8000_0000, 32'h8000_0000, 0, lat, d, st, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL mulh_edge_done: timeout lat %0d", lat);
    end
    tests++;
    if (d !== 32'h4000_0000) begin
      fails++;
      $display("FAIL mulh_edge_data: got %h want 40000000", d);
    end
    tests++;
    if (lat != 36) begin
      fails++;
      $display("FAIL mulh_edge_lat: got %0d want 36", lat);
    end
    tests++;
    if (resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL mulh_edge_after: resp_valid %b want 0", resp_valid);
    end
  endtask

  task automatic test_cache_hit;
    int lat, s0, s1;
    logic [31:0] d;
    bit st, ok;
    s0 = stb_cnt;
    run_req(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, d, st, ok);
    tests++;
    if (!ok || d !== 32'hFFFF_FFFE) begin
      fails++;
      $display("FAIL mulhu_data: got %h ok %b want fffffffe", d, ok);
    end
    tests++;
    if (lat != 36) begin
      fails++;
      $display("FAIL mulhu_lat: got %0d want 36", lat);
    end
    s1 = stb_cnt;
    tests++;
    if (s1 - s0 != 1) begin
      fails++;
      $display("FAIL mulhu_stb: got %0d strobes want 1", s1 - s0);
    end
    run_req(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, d, st, ok);
    tests++;
    if (!ok || d !== 32'h0000_0001) begin
      fails++;
      $display("FAIL hit_data: got %h ok %b want 00000001", d, ok);
    end
    tests++;
    if (lat != 1) begin
      fails++;
      $display("FAIL hit_lat: got %0d want 1", lat);
    end
    tests++;
    if (stb_cnt != s1) begin
      fails++;
      $display("FAIL hit_stb: got %0d strobes want 0", stb_cnt - s1);
    end
  endtask

  task automatic test_mulhsu_miss;
    int lat;
    logic [31:0] d;
    bit st, ok;
    run_req(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, d, st, ok);
    tests++;
    if (!ok || d !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL mulhsu_data: got %h ok %b want ffffffff", d, ok);
    end
    run_req(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, d, st, ok);
    tests++;
    if (!ok || d !== 32'h0000_0000) begin
      fails++;
      $display("FAIL mulh_m1_data: got %h ok %b want 00000000", d, ok);
    end
    tests++;
    if (lat != 36) begin
      fails++;
      $display("FAIL mulh_m1_lat: got %0d want 36 (miss)", lat);
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [31:0] d;
    bit st, ok, extra;
    run_req(2'd0, 32'h0000_1234, 32'h0001_0000, 10, lat, d, st, ok);
    tests++;
    if (!ok || d !== 32'h1234_0000) begin
      fails++;
      $display("FAIL bp_data: got %h ok %b want 12340000", d, ok);
    end
    tests++;
    if (!st) begin
      fails++;
      $display("FAIL bp_stable: resp changed while stalled, got 0 want 1");
    end
    extra = 1'b0;
    repeat (3) begin
      if (resp_valid) extra = 1'b1;
      @(negedge clk);
    end
    tests++;
    if (extra) begin
      fails++;
      $display("FAIL bp_single: extra resp_valid got 1 want 0");
    end
  endtask

  task automatic test_flush;
    int k, lat, n;
    logic [31:0] d;
    bit st, ok, saw;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 2'd0;
    req_a = 32'd7;
    req_b = 32'd6;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    repeat (4) begin
      @(negedge clk);
      k++;
    end
    flush = 1'b1;
    @(negedge clk);
    k++;
    flush = 1'b0;
    saw = 1'b0;
    while (!req_ready && k < 100) begin
      if (resp_valid) saw = 1'b1;
      @(negedge clk);
      k++;
    end
    m_vld = 1'b0;
    tests++;
    if (saw) begin
      fails++;
      $display("FAIL flush_noresp: resp_valid got 1 want 0");
    end
    tests++;
    if (k != 36) begin
      fails++;
      $display("FAIL flush_drain: req_ready at %0d want 36", k);
    end
    run_req(2'd0, 32'd7, 32'd6, 0, lat, d, st, ok);
    tests++;
    if (!ok || d !== 32'h0000_002A) begin
      fails++;
      $display("FAIL flush_retry_data: got %h ok %b want 0000002a", d, ok);
    end
    tests++;
    if (lat != 36) begin
      fails++;
      $display("FAIL flush_retry_lat: got %0d want 36", lat);
    end
  endtask

  task automatic test_reset_mid;
    int lat, n;
    logic [31:0] d;
    bit st, ok;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 2'd3;
    req_a = 32'd9;
    req_b = 32'd9;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_vld = 1'b0;
    tests++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_state: rv %b busy %b rdy %b want 0 0 1",
               resp_valid, busy, req_ready);
    end
    run_req(2'd0, 32'd7, 32'd6, 0, lat, d, st, ok);
    tests++;
    if (!ok || d !== 32'h0000_002A || lat != 36) begin
      fails++;
      $display("FAIL rstmid_miss: got %h lat %0d want 0000002a lat 36",
               d, lat);
    end
    run_req(2'd0, 32'd3, 32'd5, 0, lat, d, st, ok);
    tests++;
    if (!ok || d !== 32'h0000_000F) begin
      fails++;
      $display("FAIL rstmid_data: got %h ok %b want 0000000f", d, ok);
    end
    tests++;
    if (lat != 36) begin
      fails++;
      $display("FAIL rstmid_lat: got %0d want 36", lat);
    end
  endtask

  task automatic test_random;
    int lat, exp_lat, hold;
    logic [31:0] d, a, b, e;
    logic [31:0] pool [4];
    logic [1:0] op;
    bit st, ok;
    pool[0] = 32'h0;
    pool[1] = 32'hFFFF_FFFF;
    pool[2] = 32'h8000_0000;
    pool[3] = 32'h7FFF_FFFF;
    a = '0;
    b = '0;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      if (i == 0 || $urandom_range(0, 1) == 0) begin
        a = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)]
                                        : $urandom;
        b = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 3)]
                                        : $urandom;
      end
      hold = $urandom_range(0, 3);
      exp_lat = model_hit(op, a, b) ? 1 : 36;
      e = model_res(op, a, b);
      run_req(op, a, b, hold, lat, d, st, ok);
      tests++;
      if (!ok || d !== e) begin
        fails++;
        $display("FAIL rand_data[%0d]: op %0d a %h b %h got %h want %h",
                 i, op, a, b, d, e);
      end
      tests++;
      if (lat != exp_lat) begin
        fails++;
        $display("FAIL rand_lat[%0d]: op %0d got %0d want %0d",
                 i, op, lat, exp_lat);
      end
      tests++;
      if (!st) begin
        fails++;
        $display("FAIL rand_stable[%0d]: got 0 want 1", i);
      end
    end
  endtask

  initial begin
    test_reset;
    test_mulh_edge;
    test_cache_hit;
    test_mulhsu_miss;
    test_backpressure;
    test_flush;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
